tdoa_capture_counter: RTL and testbench
=======================================

Name: tdoa_capture_counter

Overview:
- Parametrised free-running timebase counter with per-channel timestamp capture for hydrophone time-difference-of-arrival measurement.
- Keeps the 2-bit select control (clear/hold/load/count) and adds:
  - a load mode;
  - wrap-or-saturate overflow handling with a sticky overflow flag;
  - NUM_CH first-hit capture registers, one per hydrophone channel, re-armed by a single arm strobe.
- Sits between the per-channel ping detectors and the host readout logic.

Parameters:
WIDTH, 20, counter and timestamp width in bits (minimum 2)
NUM_CH, 4, number of capture channels (minimum 1)
SATURATE, 0, 0 = counter wraps at max; 1 = counter sticks at all-ones

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_b  input  1  asynchronous active-low reset
counter_sel  input  2  00 clear, 01 hold, 10 load, 11 count
load_value  input  WIDTH  value loaded when counter_sel = 10
arm  input  1  single-cycle strobe; clears all captures and re-arms channels
ch_trig  input  NUM_CH  per-channel detect; bit i high requests capture on channel i
counter_value  output  WIDTH  current counter register
overflow  output  1  sticky: counter reached its limit while counting
cap_value  output  NUM_CH*WIDTH  flattened timestamps, channel i at [i*WIDTH +: WIDTH]
cap_valid  output  NUM_CH  bit i set once channel i has captured since last arm
all_valid  output  1  combinational AND of all cap_valid bits

Behaviour:
- Reset: asynchronous on reset_b low; all state forced to 0 immediately. Releases on next clk edge with reset_b high.
  - Reset values: counter_value = 0, overflow = 0, cap_value = 0, cap_valid = 0, all_valid = 0.
  - Reset mid-operation discards all captures; no partial state survives.
- Counter update, registered, 1-cycle latency:
  - 00: counter <= 0; overflow <= 0.
  - 01: counter holds; overflow holds.
  - 10: counter <= load_value; overflow <= 0.
  - 11: counter increments.
- Count at all-ones (counter = 2^WIDTH-1 and sel = 11):
  - SATURATE=0: counter <= 0, overflow <= 1.
  - SATURATE=1: counter stays at all-ones, overflow <= 1.
- overflow stays set through hold and count; only clear (00), load (10) or reset clear it.
- All arithmetic is unsigned, WIDTH bits; no carry-out port.
- Capture, per channel i, registered:
  - If arm = 0, ch_trig[i] = 1 and cap_valid[i] = 0: cap_value[i] <= counter_value as seen before this edge (pre-update value), and cap_valid[i] <= 1.
  - If cap_valid[i] = 1: further ch_trig[i] is ignored (first-hit only). cap_value[i] is stable until the next arm or reset.
  - ch_trig is level-sampled; a multi-cycle trigger captures exactly once.
- Multiple channels triggering on the same edge each capture the same timestamp.
- Capture works in every counter_sel mode; it records whatever counter_value currently holds.
- arm = 1: all cap_valid <= 0 and all cap_value <= 0 on that edge.
  - arm has priority over ch_trig on the same cycle; those triggers are dropped.
  - Channels capture again from the next cycle.
- Counter and capture are independent: a simultaneous counter_sel change and trigger capture the old counter value.
- all_valid follows cap_valid with no extra latency.
- No clock enable and no other state.

Test Plan:
1. Reset check: hold reset_b low for 3 cycles with sel = 11 and all triggers high -> all outputs 0. Release reset, then sel = 11 for 10 cycles -> counter_value = 10, overflow = 0.
2. Count/load/hold sequence:
   - sel = 10 with load_value = 0x00100 -> counter reads 0x00100 next cycle.
   - sel = 01 for 5 cycles -> stays 0x00100.
   - sel = 11 for 3 cycles -> 0x00103.
   - sel = 00 -> 0.
3. Wrap vs saturate, using WIDTH = 4 instances: load 14, then count 3 cycles.
   - SATURATE=0 -> 15, 0, 1, overflow = 1.
   - SATURATE=1 -> 15, 15, 15, overflow = 1.
   - Then sel = 00 -> counter 0, overflow 0.
4. Multi-channel capture, counting from 0:
   - ch_trig[1] pulsed when counter = 5, ch_trig[0] at 9, ch_trig[2] and [3] together at 12.
   - Expect cap_value = {12, 12, 5, 9} for channels 3..0, and all_valid = 1 after the cycle at 12.
   - A re-trigger of channel 1 at 20 leaves its cap_value at 5.
5. Arm priority: with all channels valid, assert arm and ch_trig = 4'b1111 on the same cycle.
   - Next cycle: cap_valid = 0 and cap_value = 0.
   - ch_trig[2] one cycle later captures the counter value at that edge.
6. Reset mid-capture: with two channels valid and counter = 0x12345, pulse reset_b low asynchronously between clock edges.
   - Outputs go to 0 immediately, without waiting for a clock edge.
   - After release, counting restarts from 0.

Source files
------------

// File: rtl/tdoa_capture_counter.sv
// tdoa_capture_counter
//   Free-running timebase for hydrophone time-difference-of-arrival work.
//   A WIDTH-bit counter (clear/hold/load/count) with wrap or saturate on
//   overflow and a sticky overflow flag, plus NUM_CH first-hit timestamp
//   capture lanes that all re-arm on a single arm strobe.
//
//   Ports
//     clk           system clock, rising edge
//     reset_b       asynchronous active-low reset
//     counter_sel   00 clear, 01 hold, 10 load, 11 count
//     load_value    value taken when counter_sel = 10
//     arm           clears all captures, channels re-arm next cycle
//     ch_trig       per-channel detect, level sampled
//     counter_value current counter register
//     overflow      sticky, set when a count hits the limit
//     cap_value     timestamps, channel i at [i*WIDTH +: WIDTH]
//     cap_valid     channel i has captured since last arm
//     all_valid     AND of cap_valid

// One capture lane: latches the pre-update counter on the first trigger
// after arm, then ignores the channel until the next arm or reset.
module tdoa_cap_lane #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic [WIDTH-1:0] cap_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             vld_q, vld_d;

  always_comb begin
    cap_d = cap_q;
    vld_d = vld_q;
    if (arm_i) begin
      // arm wins over a same-cycle trigger; that trigger is lost
      cap_d = '0;
      vld_d = 1'b0;
    end else if (trig_i && !vld_q) begin
      cap_d = cnt_i;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cap_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      vld_q <= vld_d;
    end
  end

  assign cap_o = cap_q;
  assign vld_o = vld_q;
endmodule

module tdoa_capture_counter #(
  parameter int WIDTH    = 20,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [1:0]              counter_sel,
  input  logic [WIDTH-1:0]        load_value,
  input  logic                    arm,
  input  logic [NUM_CH-1:0]       ch_trig,
  output logic [WIDTH-1:0]        counter_value,
  output logic                    overflow,
  output logic [NUM_CH*WIDTH-1:0] cap_value,
  output logic [NUM_CH-1:0]       cap_valid,
  output logic                    all_valid
);
  localparam logic [1:0] SEL_CLR  = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_CNT  = 2'b11;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (counter_sel)
      SEL_CLR: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      SEL_HOLD: ;
      SEL_LOAD: begin
        cnt_d = load_value;
        ovf_d = 1'b0;
      end
      SEL_CNT: begin
        if (at_max) begin
          cnt_d = (SATURATE != 0) ? cnt_q : '0;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign counter_value = cnt_q;
  assign overflow      = ovf_q;

  // lanes see cnt_q, so a trigger coincident with a sel change records the
  // value before the counter updates
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tdoa_cap_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .reset_b(reset_b),
      .arm_i  (arm),
      .trig_i (ch_trig[i]),
      .cnt_i  (cnt_q),
      .cap_o  (cap_value[i*WIDTH +: WIDTH]),
      .vld_o  (cap_valid[i])
    );
  end

  assign all_valid = &cap_valid;
endmodule

// File: tb/tb_tdoa_capture_counter.sv
// Bench for tdoa_capture_counter. Three instances share one stimulus:
// u0 WIDTH=20 wrap, u1 WIDTH=4 wrap, u2 WIDTH=4 saturate. A behavioural
// model per instance is compared on every falling edge; directed steps
// also check hand-computed literals.
module tb_tdoa_capture_counter;
  localparam int W = 20;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_b;
  logic [1:0]   sel;
  logic [W-1:0] ld;
  logic         arm;
  logic [N-1:0] trig;

  logic [W-1:0]   cv0;
  logic           ov0, av0;
  logic [N*W-1:0] cp0;
  logic [N-1:0]   vl0;
  logic [3:0]     cv1, cv2;
  logic           ov1, ov2, av1, av2;
  logic [N*4-1:0] cp1, cp2;
  logic [N-1:0]   vl1, vl2;

  tdoa_capture_counter #(.WIDTH(W), .NUM_CH(N), .SATURATE(0)) u0 (
    .clk(clk), .reset_b(reset_b), .counter_sel(sel), .load_value(ld),
    .arm(arm), .ch_trig(trig), .counter_value(cv0), .overflow(ov0),
    .cap_value(cp0), .cap_valid(vl0), .all_valid(av0));
  tdoa_capture_counter #(.WIDTH(4), .NUM_CH(N), .SATURATE(0)) u1 (
    .clk(clk), .reset_b(reset_b), .counter_sel(sel), .load_value(ld[3:0]),
    .arm(arm), .ch_trig(trig), .counter_value(cv1), .overflow(ov1),
    .cap_value(cp1), .cap_valid(vl1), .all_valid(av1));
  tdoa_capture_counter #(.WIDTH(4), .NUM_CH(N), .SATURATE(1)) u2 (
    .clk(clk), .reset_b(reset_b), .counter_sel(sel), .load_value(ld[3:0]),
    .arm(arm), .ch_trig(trig), .counter_value(cv2), .overflow(ov2),
    .cap_value(cp2), .cap_valid(vl2), .all_valid(av2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned     wd [3] = '{20, 4, 4};
  bit              sat[3] = '{1'b0, 1'b0, 1'b1};
  longint unsigned m_cnt[3];
  bit              m_ovf[3];
  longint unsigned m_cap[3][N];
  bit              m_cv [3][N];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
      for (int c = 0; c < N; c++) begin
        m_cap[k][c] = 0;
        m_cv[k][c]  = 0;
      end
    end
  end

  always @(posedge clk or negedge reset_b) begin
    longint unsigned mx, old;
    for (int k = 0; k < 3; k++) begin
      mx = (64'd1 << wd[k]) - 1;
      if (!reset_b) begin
        m_cnt[k] = 0;
        m_ovf[k] = 0;
        for (int c = 0; c < N; c++) begin
          m_cap[k][c] = 0;
          m_cv[k][c]  = 0;
        end
      end else begin
        old = m_cnt[k];
        for (int c = 0; c < N; c++) begin
          if (arm) begin
            m_cap[k][c] = 0;
            m_cv[k][c]  = 0;
          end else if (trig[c] && !m_cv[k][c]) begin
            m_cap[k][c] = old;
            m_cv[k][c]  = 1;
          end
        end
        case (sel)
          2'b00: begin m_cnt[k] = 0; m_ovf[k] = 0; end
          2'b01: ;
          2'b10: begin m_cnt[k] = longint'(ld) & mx; m_ovf[k] = 0; end
          default: begin
            if (old == mx) begin
              m_cnt[k] = sat[k] ? mx : 0;
              m_ovf[k] = 1;
            end else begin
              m_cnt[k] = old + 1;
            end
          end
        endcase
      end
    end
  end

  function automatic logic [63:0] d_cnt(int k);
    return (k == 0) ? 64'(cv0) : (k == 1) ? 64'(cv1) : 64'(cv2);
  endfunction
  function automatic logic d_ovf(int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction
  function automatic logic [63:0] d_cap(int k, int c);
    return (k == 0) ? 64'(cp0[c*W +: W]) : (k == 1) ? 64'(cp1[c*4 +: 4]) : 64'(cp2[c*4 +: 4]);
  endfunction
  function automatic logic d_vld(int k, int c);
    return (k == 0) ? vl0[c] : (k == 1) ? vl1[c] : vl2[c];
  endfunction
  function automatic logic d_all(int k);
    return (k == 0) ? av0 : (k == 1) ? av1 : av2;
  endfunction

  // every-cycle compare against the model
  always @(negedge clk) begin
    bit all_m;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d counter", k), d_cnt(k), m_cnt[k]);
      chk($sformatf("u%0d overflow", k), 64'(d_ovf(k)), 64'(m_ovf[k]));
      all_m = 1;
      for (int c = 0; c < N; c++) begin
        chk($sformatf("u%0d cap%0d", k, c), d_cap(k, c), m_cap[k][c]);
        chk($sformatf("u%0d vld%0d", k, c), 64'(d_vld(k, c)), 64'(m_cv[k][c]));
        all_m = all_m & m_cv[k][c];
      end
      chk($sformatf("u%0d all_valid", k), 64'(d_all(k)), 64'(all_m));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_b = 1'b0;
    sel     = 2'b11;
    ld      = '0;
    arm     = 1'b0;
    trig    = 4'hF;

    // 1: reset holds everything at zero despite count and triggers
    cyc(3);
    chk("rst cnt", 64'(cv0), 0);
    chk("rst ovf", 64'(ov0), 0);
    chk("rst cap", 64'(cp0), 0);
    chk("rst vld", 64'(vl0), 0);
    chk("rst all", 64'(av0), 0);
    reset_b = 1'b1;
    trig    = '0;
    cyc(10);
    chk("cnt10 u0", 64'(cv0), 10);
    chk("cnt10 u1", 64'(cv1), 10);
    chk("cnt10 ovf", 64'(ov0), 0);

    // 2: load / hold / count / clear
    sel = 2'b10; ld = 20'h00100; cyc();
    chk("load", 64'(cv0), 64'h100);
    sel = 2'b01; cyc(5);
    chk("hold", 64'(cv0), 64'h100);
    sel = 2'b11; cyc(3);
    chk("count3", 64'(cv0), 64'h103);
    sel = 2'b00; cyc();
    chk("clear", 64'(cv0), 0);

    // 3: wrap vs saturate on the 4-bit instances
    sel = 2'b10; ld = 20'd14; cyc();
    sel = 2'b11; cyc();
    chk("wrap c1", 64'(cv1), 15);
    chk("sat c1", 64'(cv2), 15);
    cyc();
    chk("wrap c2", 64'(cv1), 0);
    chk("sat c2", 64'(cv2), 15);
    cyc();
    chk("wrap c3", 64'(cv1), 1);
    chk("sat c3", 64'(cv2), 15);
    chk("wrap ovf", 64'(ov1), 1);
    chk("sat ovf", 64'(ov2), 1);
    sel = 2'b00; cyc();
    chk("clr cnt", 64'(cv2), 0);
    chk("clr ovf", 64'(ov2), 0);

    // 4: multi-channel capture while counting from 0
    sel = 2'b11; cyc(5);                    // counter 5
    trig = 4'b0010; cyc();                  // ch1 <- 5
    trig = 4'b0000; cyc(3);                 // counter 9
    trig = 4'b0001; cyc();                  // ch0 <- 9
    trig = 4'b0000; cyc(2);                 // counter 12
    trig = 4'b1100; cyc();                  // ch2,ch3 <- 12
    trig = 4'b0000;
    chk("caps", 64'(cp0), {20'd12, 20'd12, 20'd5, 20'd9});
    chk("all_valid", 64'(av0), 1);
    cyc(7);                                 // counter 20
    trig = 4'b0010; cyc();
    chk("retrig ch1", 64'(cp0[1*W +: W]), 5);

    // 5: arm beats same-cycle triggers
    arm = 1'b1; trig = 4'b1111; cyc();      // counter 22
    arm = 1'b0; trig = 4'b0000;
    chk("arm vld", 64'(vl0), 0);
    chk("arm cap", 64'(cp0), 0);
    cyc();                                  // counter 23
    trig = 4'b0100; cyc();
    trig = 4'b0000;
    chk("rearm cap2", 64'(cp0[2*W +: W]), 23);
    chk("rearm vld", 64'(vl0), 4'b0100);

    // 6: asynchronous reset between edges
    sel = 2'b10; ld = 20'h12345; cyc();
    sel = 2'b01; trig = 4'b0001; cyc();
    trig = 4'b0000;
    chk("pre cap0", 64'(cp0[W-1:0]), 64'h12345);
    chk("pre vld", 64'(vl0), 4'b0101);
    #2 reset_b = 1'b0;
    #1;
    chk("async cnt", 64'(cv0), 0);
    chk("async cap", 64'(cp0), 0);
    chk("async vld", 64'(vl0), 0);
    chk("async all", 64'(av0), 0);
    @(posedge clk);
    #1 reset_b = 1'b1;
    sel = 2'b11;
    cyc(3);
    chk("restart", 64'(cv0), 3);

    // randomized traffic, checked by the model every cycle
    repeat (3000) begin
      int r;
      r = $urandom_range(0, 99);
      sel = (r < 60) ? 2'b11 : (r < 75) ? 2'b01 : (r < 88) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 3) == 0) ld = 20'hFFFFF - 20'($urandom_range(0, 5));
      else ld = 20'($urandom);
      arm = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < N; c++) trig[c] = ($urandom_range(0, 7) == 0);
      cyc();
    end
    arm = 1'b0; trig = '0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
